// File: rtl/accum_cmp_pkg.sv
// Shared constants for the accumulate-and-compare block: FSM state codes
// and width helpers used by the RTL and the bench.
package accum_cmp_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_ADD   = 3'd1;
    localparam logic [STATE_W-1:0] S_COMP  = 3'd2;
    localparam logic [STATE_W-1:0] S_SMALL = 3'd3;
    localparam logic [STATE_W-1:0] S_LARGE = 3'd4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // At least one guard bit so a single operand plus carry still fits.
    function automatic int acc_width(input int w, input int n);
        return (clog2(n) < 1) ? w + 1 : w + clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/accum_cmp_dp.sv
// Datapath: operand accumulator, operand counter, latched threshold,
// comparator and the sticky result bit.
module accum_cmp_dp
    import accum_cmp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4,
    parameter int ACC_W   = acc_width(WIDTH, NUM_OPS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             acc_en_i,
    input  logic             set_result_i,
    input  logic             result_val_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [ACC_W-1:0] threshold_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             result_o,
    output logic             last_o,
    output logic             lt_o
);

    localparam int CNT_W = cnt_width(NUM_OPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic             res_q, res_d;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        thr_d = thr_q;
        res_d = res_q;
        if (clear_i) begin
            sum_d = '0;
            cnt_d = '0;
            thr_d = threshold_i;
            res_d = 1'b0;
        end else begin
            if (acc_en_i) begin
                sum_d = sum_q + {{(ACC_W-WIDTH){1'b0}}, in_data_i};
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (set_result_i) res_d = result_val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q <= '0;
            cnt_q <= '0;
            thr_q <= '0;
            res_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            thr_q <= thr_d;
            res_q <= res_d;
        end
    end

    assign sum_o    = sum_q;
    assign result_o = res_q;
    assign last_o   = (cnt_q == LAST_CNT);
    assign lt_o     = (sum_q < thr_q);

endmodule

// File: rtl/accum_cmp_fsm.sv
// Control FSM: accepts a job, accumulates NUM_OPS operands under
// back-pressure, compares the sum against the latched threshold.
module accum_cmp_fsm
    import accum_cmp_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  NUM_OPS = 4,
    localparam int ACC_W   = acc_width(WIDTH, NUM_OPS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [ACC_W-1:0] threshold_i,
    output logic             in_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             result_o,
    output logic [ACC_W-1:0] sum_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic clear, acc_en, set_result, result_val;
    logic last, lt;

    always_comb begin
        state_d    = state_q;
        clear      = 1'b0;
        acc_en     = 1'b0;
        set_result = 1'b0;
        result_val = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    clear   = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (in_valid_i) begin
                    acc_en = 1'b1;
                    if (last) state_d = S_COMP;
                end
            end
            S_COMP:  state_d = lt ? S_SMALL : S_LARGE;
            S_SMALL: begin
                set_result = 1'b1;
                result_val = 1'b1;
                state_d    = S_IDLE;
            end
            S_LARGE: begin
                set_result = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    assign in_ready_o = (state_q == S_ADD);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_SMALL) || (state_q == S_LARGE);

    accum_cmp_dp #(
        .WIDTH   (WIDTH),
        .NUM_OPS (NUM_OPS),
        .ACC_W   (ACC_W)
    ) u_dp (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (clear),
        .acc_en_i     (acc_en),
        .set_result_i (set_result),
        .result_val_i (result_val),
        .in_data_i    (in_data_i),
        .threshold_i  (threshold_i),
        .sum_o        (sum_o),
        .result_o     (result_o),
        .last_o       (last),
        .lt_o         (lt)
    );

endmodule

// File: tb/tb_accum_cmp_fsm.sv
// Self-checking bench for accum_cmp_fsm: directed vector table, reset
// corner cases, and randomized jobs against an arithmetic reference.
module tb_accum_cmp_fsm;
    import accum_cmp_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 4;
    localparam int ACC_W   = acc_width(WIDTH, NUM_OPS);

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic [WIDTH-1:0] in_data_i = '0;
    logic [ACC_W-1:0] threshold_i = '0;
    logic             in_ready_o, busy_o, done_o, result_o;
    logic [ACC_W-1:0] sum_o;

    int checks = 0;
    int errors = 0;

    accum_cmp_fsm #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .threshold_i (threshold_i),
        .in_ready_o  (in_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .sum_o       (sum_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ACC_W-1:0]                  thr;
        logic [NUM_OPS-1:0][WIDTH-1:0]     d;
        logic [NUM_OPS-1:0][1:0]           gap;
        logic [ACC_W-1:0]                  exp_sum;
        logic                              exp_res;
        bit                                noise;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mkv(input int thr, input int d0, input int d1, input int d2,
                                 input int d3, input int g0, input int g1, input int g2,
                                 input int g3, input int es, input bit er, input bit nz);
        vec_t v;
        v.thr = ACC_W'(thr);
        v.d[0] = WIDTH'(d0); v.d[1] = WIDTH'(d1); v.d[2] = WIDTH'(d2); v.d[3] = WIDTH'(d3);
        v.gap[0] = 2'(g0); v.gap[1] = 2'(g1); v.gap[2] = 2'(g2); v.gap[3] = 2'(g3);
        v.exp_sum = ACC_W'(es);
        v.exp_res = er;
        v.noise = nz;
        return v;
    endfunction

    // Junk on ignored inputs while a job is in flight.
    task automatic scramble(input bit noise);
        if (noise) begin
            start_i     = 1'($urandom_range(0, 1));
            threshold_i = ACC_W'($urandom);
        end
    endtask

    task automatic run_job(input vec_t v);
        start_i = 1'b1; threshold_i = v.thr; in_valid_i = v.noise; in_data_i = 8'hAA;
        chk("idle_busy", busy_o, 0);
        chk("idle_ready", in_ready_o, 0);
        tick;
        start_i = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            for (int g = 0; g < int'(v.gap[k]); g++) begin
                in_valid_i = 1'b0; in_data_i = WIDTH'($urandom); scramble(v.noise);
                chk("gap_ready", in_ready_o, 1);
                chk("gap_done", done_o, 0);
                tick;
            end
            in_valid_i = 1'b1; in_data_i = v.d[k]; scramble(v.noise);
            chk("add_ready", in_ready_o, 1);
            chk("add_busy", busy_o, 1);
            chk("add_done", done_o, 0);
            tick;
        end
        in_valid_i = v.noise; in_data_i = WIDTH'($urandom); start_i = v.noise;
        chk("comp_ready", in_ready_o, 0);
        chk("comp_busy", busy_o, 1);
        chk("comp_done", done_o, 0);
        tick;
        start_i = v.noise;
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 1);
        tick;
        start_i = 1'b0; in_valid_i = 1'b0;
        chk("after_done", done_o, 0);
        chk("after_busy", busy_o, 0);
        chk("sum", sum_o, v.exp_sum);
        chk("result", result_o, v.exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int   s;

        tbl[0] = mkv(11,   1, 2, 3, 4,         0, 0, 0, 0,  10,   1'b1, 1'b0);
        tbl[1] = mkv(10,   1, 2, 3, 4,         0, 0, 0, 0,  10,   1'b0, 1'b0);
        tbl[2] = mkv(1021, 255, 255, 255, 255, 0, 0, 0, 0,  1020, 1'b1, 1'b0);
        tbl[3] = mkv(1020, 255, 255, 255, 255, 0, 0, 0, 0,  1020, 1'b0, 1'b0);
        tbl[4] = mkv(16,   5, 7, 1, 2,         0, 2, 0, 0,  15,   1'b1, 1'b0);
        tbl[5] = mkv(0,    0, 0, 0, 0,         0, 0, 0, 0,  0,    1'b0, 1'b1);
        tbl[6] = mkv(1023, 0, 0, 0, 1,         1, 0, 1, 2,  1,    1'b1, 1'b1);
        tbl[7] = mkv(100,  50, 25, 20, 5,      2, 2, 2, 2,  100,  1'b0, 1'b1);

        tick; tick;
        chk("rst_ready", in_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_sum", sum_o, 0);
        reset_i = 1'b0;

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Reset beats start, and clears a held result of 1.
        run_job(tbl[0]);
        reset_i = 1'b1; start_i = 1'b1;
        tick;
        reset_i = 1'b0; start_i = 1'b0;
        chk("rst_idle_busy", busy_o, 0);
        chk("rst_idle_result", result_o, 0);
        chk("rst_idle_sum", sum_o, 0);

        // Reset mid-ADD after the second operand, start pulsed while busy.
        start_i = 1'b1; threshold_i = ACC_W'(5);
        tick;
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 8'd9;
        tick;
        start_i = 1'b1; threshold_i = ACC_W'(500);
        tick;
        start_i = 1'b0; in_valid_i = 1'b0;
        chk("mid_sum", sum_o, 18);
        chk("mid_ready", in_ready_o, 1);
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", in_ready_o, 0);
        chk("mid_rst_sum", sum_o, 0);
        chk("mid_rst_result", result_o, 0);
        run_job(tbl[4]);

        for (int n = 0; n < 25; n++) begin
            s = 0;
            for (int k = 0; k < NUM_OPS; k++) begin
                rv.d[k]   = WIDTH'($urandom);
                rv.gap[k] = 2'($urandom_range(0, 2));
                s += int'(rv.d[k]);
            end
            rv.thr = ($urandom_range(0, 3) == 0) ? ACC_W'(s) : ACC_W'($urandom_range(0, 1023));
            rv.exp_sum = ACC_W'(s);
            rv.exp_res = (s < int'(rv.thr));
            rv.noise = 1'($urandom_range(0, 1));
            run_job(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
